// File: rtl/rnd_range_draw.sv
// Draws a uniform value in [0, RANGE) and a direction bit from the LFSR bit stream.
// Uses rejection sampling with a fold fallback after MAX_TRIES attempts.
module rnd_range_draw #(
  parameter int WIDTH     = 16,
  parameter int RANGE     = 480,
  parameter int MAX_TRIES = 4,
  localparam int OUT_W    = $clog2(RANGE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rnd_num_i,
  input  logic             req_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [OUT_W-1:0] value_o,
  output logic             dir_o
);

  localparam int CW = $clog2(OUT_W + 1);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [OUT_W:0] RANGE_W = (OUT_W+1)'(RANGE);
  localparam logic [CW-1:0]  LAST_BIT = CW'(OUT_W);
  localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CHECK
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W:0]   sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    try_q, try_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             dir_q, dir_d;

  logic [OUT_W-1:0] cand;
  logic             cand_dir;
  logic             in_range;
  logic [OUT_W-1:0] folded;
  logic             unused_hi;

  // Only the fresh feedback bit carries new entropy each cycle.
  assign unused_hi = ^rnd_num_i[WIDTH-1:1];

  assign cand     = sh_q[OUT_W-1:0];
  assign cand_dir = sh_q[OUT_W];
  assign in_range = {1'b0, cand} < RANGE_W;
  // 2^OUT_W < 2*RANGE, so one subtraction always lands in range.
  assign folded   = cand - RANGE_W[OUT_W-1:0];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      try_q   <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      try_q   <= try_d;
      valid_q <= valid_d;
      value_q <= value_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: collect OUT_W+1 bits, then accept, retry or fold.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    try_d   = try_q;
    valid_d = 1'b0;
    value_d = value_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          try_d   = '0;
        end
      end
      SAMPLE: begin
        sh_d  = {sh_q[OUT_W-1:0], rnd_num_i[0]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (in_range) begin
          value_d = cand;
          dir_d   = cand_dir;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (try_q != LAST_TRY) begin
          try_d   = try_q + 1'b1;
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          value_d = folded;
          dir_d   = cand_dir;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = valid_q;
  assign value_o = value_q;
  assign dir_o   = dir_q;

endmodule

// File: doc/rnd_range_draw.md
Name: rnd_range_draw

Overview:
- Consumer end of the game's 16-bit LFSR stream.
- Turns the free-running pseudo-random word into a uniformly distributed value in [0, RANGE) plus one random direction bit, on request.
- Used by the pong game logic at serve time to pick the ball's start row and its horizontal direction.
- Sits between the LFSR generator and the ball/serve state machine, with a req/valid handshake towards the game logic.

Parameters:
- WIDTH, 16: width of the incoming random word.
- RANGE, 480: number of legal output values; output is 0..RANGE-1. Must be >= 2.
- OUT_W, $clog2(RANGE): output width; derived, not overridden.
- MAX_TRIES, 4: rejection-sampling attempts before the fold fallback is used. Must be >= 1.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- rnd_num_i  input  WIDTH  free-running random word; only bit 0 is used, as it is the fresh LFSR feedback bit each cycle
- req_i  input  1  draw request; sampled only in IDLE
- busy_o  output  1  high while state != IDLE
- valid_o  output  1  one-cycle pulse: value_o and dir_o are updated
- value_o  output  OUT_W  drawn value, held until the next valid_o
- dir_o  output  1  drawn direction bit, held until the next valid_o

Behaviour:
- Interface is fixed: one clock, clk_i; synchronous active-high reset, rst_i.
- Reset: state=IDLE; shift register, bit counter and try counter = 0; valid_o=0, busy_o=0, value_o=0, dir_o=0.
- FSM states: IDLE, SAMPLE, CHECK.
- IDLE:
  - req_i=1 -> SAMPLE, with bit counter=0 and try counter=0.
  - req_i=0 -> stay in IDLE.
- SAMPLE:
  - Each cycle, shift register sh (OUT_W+1 bits) <= {sh[OUT_W-1:0], rnd_num_i[0]}; bit counter increments.
  - After OUT_W+1 shifts (counter == OUT_W in the current cycle) -> CHECK.
  - First bit shifted becomes dir; the remaining OUT_W bits form the candidate, MSB first.
- CHECK (one cycle). Candidate c = sh[OUT_W-1:0], direction = sh[OUT_W].
  - c < RANGE: register value_o=c, dir_o=sh[OUT_W]; valid_o=1 next cycle; -> IDLE.
  - c >= RANGE and try counter < MAX_TRIES-1: try counter++, bit counter=0; -> SAMPLE.
  - c >= RANGE and try counter == MAX_TRIES-1: value_o = c - RANGE (always in range because 2^OUT_W < 2*RANGE); dir_o as above; valid_o next cycle; -> IDLE.
- Timing (request seen in cycle 0):
  - SAMPLE occupies cycles 1..OUT_W+1; CHECK is cycle OUT_W+2.
  - valid_o is high in cycle OUT_W+3, with state already IDLE.
  - Each retry adds OUT_W+2 cycles. For defaults: first-try valid at cycle 12, worst case at cycle 45.
- valid_o is registered and high for exactly one cycle per accepted request.
- req_i while busy_o=1 is ignored, not queued.
- req_i in the valid_o cycle is accepted, because the state is IDLE.
- If RANGE is a power of two, no rejection ever occurs.
- Subtraction is OUT_W bits wide, unsigned.
- rst_i mid-operation: abort immediately to the reset values; no valid_o is produced for the aborted request.
- Values on rnd_num_i[WIDTH-1:1] have no effect.

Test Plan:
Bench drives rnd_num_i[0] directly with bit sequences; defaults unless stated.
1. req_i pulse at cycle 0; bits 1, then 0_0110_0100 (100) -> valid_o pulse in cycle 12 only; value_o=100, dir_o=1; busy_o high in cycles 1..11.
2. First attempt bits 0,1_1111_0100 (500), then 1,0_0010_0101 (37) -> one retry, no valid_o at cycle 12; valid_o at cycle 23, value_o=37, dir_o=1.
3. Four attempts of all-ones (511, dir=1) -> fold fallback; valid_o at cycle 45, value_o=31, dir_o=1.
4. Extra req_i pulses at cycles 3 and 11 are ignored (exactly one valid_o, at cycle 12); req_i in cycle 12 starts a new draw with valid_o at cycle 24.
5. rst_i at cycle 5 of a draw -> from cycle 6: busy_o=0, valid_o=0, value_o=0, dir_o=0; no valid_o follows; a fresh req_i gives full 12-cycle latency.
6. RANGE=256 (OUT_W=8): bits 0,1111_1111 -> value_o=255 accepted on the first try, valid_o at cycle 11.
